// File: rtl/vec_pkg.sv
// Shared definitions for the iterative vector ALU.
//   VEC_LANES / VEC_LANE_W / VEC_LPC : default geometry (16 lanes x 32 bits, 4 lanes per clock)
//   OP_*                             : 2-bit opcode values on the op input
//   state_e                          : controller state encoding
package vec_pkg;

    localparam int unsigned VEC_LANES  = 16;
    localparam int unsigned VEC_LANE_W = 32;
    localparam int unsigned VEC_LPC    = 4;

    localparam logic [1:0] OP_ADD  = 2'b00;
    localparam logic [1:0] OP_SUB  = 2'b01;
    localparam logic [1:0] OP_MUL  = 2'b10;
    localparam logic [1:0] OP_MULU = 2'b11;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_RUN  = 2'b01,
        ST_DONE = 2'b10
    } state_e;

endpackage

// File: rtl/vector_alu_lane.sv
// Single-lane combinational arithmetic unit.
//   op : opcode (ADD, SUB, signed MUL, unsigned MULU)
//   a  : lane operand A, LANE_W bits
//   b  : lane operand B, LANE_W bits
//   r  : exact 2*LANE_W-bit result
module vector_alu_lane
    import vec_pkg::*;
#(
    parameter int unsigned LANE_W = VEC_LANE_W
) (
    input  logic [1:0]          op,
    input  logic [LANE_W-1:0]   a,
    input  logic [LANE_W-1:0]   b,
    output logic [2*LANE_W-1:0] r
);

    logic [2*LANE_W-1:0]        a_sext;
    logic [2*LANE_W-1:0]        b_sext;
    logic                       mul_signed;
    logic signed [LANE_W:0]     a_mul;
    logic signed [LANE_W:0]     b_mul;
    logic signed [2*LANE_W-1:0] prod;

    assign a_sext = {{LANE_W{a[LANE_W-1]}}, a};
    assign b_sext = {{LANE_W{b[LANE_W-1]}}, b};

    // One shared multiplier: a 33-bit signed operand holds either the signed
    // or the zero-extended lane value, so MUL and MULU use the same product.
    assign mul_signed = (op == OP_MUL);
    assign a_mul      = {mul_signed & a[LANE_W-1], a};
    assign b_mul      = {mul_signed & b[LANE_W-1], b};
    assign prod       = a_mul * b_mul;

    always_comb begin
        r = '0;
        case (op)
            OP_ADD:  r = a_sext + b_sext;
            OP_SUB:  r = a_sext - b_sext;
            OP_MUL:  r = prod;
            OP_MULU: r = prod;
            default: r = '0;
        endcase
    end

endmodule

// File: rtl/vector_alu.sv
// Iterative vector ALU: latches two LANES x LANE_W operand vectors and an opcode on start,
// computes LANES_PER_CYCLE lanes per clock into a registered 2*LANE_W-per-lane result,
// then pulses done for one cycle.
//   clk    : clock, all state on posedge
//   rst    : asynchronous reset, active-low
//   start  : request, honoured only in IDLE or DONE
//   op     : opcode (see vec_pkg)
//   src_a  : operand vector, lane i = src_a[i*LANE_W +: LANE_W]
//   src_b  : operand vector, same layout
//   busy   : high while lane groups are being computed
//   done   : one-cycle pulse, result valid
//   result : lane i = result[i*2*LANE_W +: 2*LANE_W]
module vector_alu
    import vec_pkg::*;
#(
    parameter int unsigned LANES           = VEC_LANES,
    parameter int unsigned LANE_W          = VEC_LANE_W,
    parameter int unsigned LANES_PER_CYCLE = VEC_LPC
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         start,
    input  logic [1:0]                   op,
    input  logic [LANES*LANE_W-1:0]      src_a,
    input  logic [LANES*LANE_W-1:0]      src_b,
    output logic                         busy,
    output logic                         done,
    output logic [2*LANES*LANE_W-1:0]    result
);

    localparam int unsigned GROUPS = LANES / LANES_PER_CYCLE;
    localparam int unsigned CNT_W  = (GROUPS > 1) ? $clog2(GROUPS) : 1;
    localparam int unsigned IDX_W  = (LANES > 1) ? $clog2(LANES) : 1;
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(GROUPS - 1);

    state_e                    state_q;
    logic [CNT_W-1:0]          cnt_q;
    logic [1:0]                op_q;
    logic [LANES*LANE_W-1:0]   a_q;
    logic [LANES*LANE_W-1:0]   b_q;
    logic                      busy_q;
    logic                      done_q;
    logic [2*LANE_W-1:0]       res_q [LANES];

    logic [IDX_W-1:0]          lane_idx [LANES_PER_CYCLE];
    logic [2*LANE_W-1:0]       lane_r   [LANES_PER_CYCLE];

    // Controller: operand capture, group counter and registered status outputs.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            op_q    <= '0;
            a_q     <= '0;
            b_q     <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            case (state_q)
                ST_IDLE, ST_DONE: begin
                    done_q <= 1'b0;
                    if (start) begin
                        op_q    <= op;
                        a_q     <= src_a;
                        b_q     <= src_b;
                        cnt_q   <= '0;
                        busy_q  <= 1'b1;
                        state_q <= ST_RUN;
                    end else begin
                        state_q <= ST_IDLE;
                    end
                end
                ST_RUN: begin
                    if (cnt_q == LAST_CNT) begin
                        cnt_q   <= '0;
                        busy_q  <= 1'b0;
                        done_q  <= 1'b1;
                        state_q <= ST_DONE;
                    end else begin
                        cnt_q <= cnt_q + CNT_W'(1);
                    end
                end
                default: begin
                    busy_q  <= 1'b0;
                    done_q  <= 1'b0;
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

    // Lane group g of the current step works on lane cnt*LANES_PER_CYCLE + g.
    for (genvar g = 0; g < LANES_PER_CYCLE; g++) begin : g_lane
        assign lane_idx[g] = IDX_W'(int'(cnt_q) * LANES_PER_CYCLE + g);

        vector_alu_lane #(
            .LANE_W (LANE_W)
        ) u_lane (
            .op (op_q),
            .a  (a_q[int'(lane_idx[g]) * LANE_W +: LANE_W]),
            .b  (b_q[int'(lane_idx[g]) * LANE_W +: LANE_W]),
            .r  (lane_r[g])
        );
    end

    // Only the active group is written; other lanes keep their previous value.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < LANES; i++) begin
                res_q[i] <= '0;
            end
        end else if (state_q == ST_RUN) begin
            for (int g = 0; g < LANES_PER_CYCLE; g++) begin
                res_q[lane_idx[g]] <= lane_r[g];
            end
        end
    end

    for (genvar i = 0; i < LANES; i++) begin : g_result
        assign result[i*2*LANE_W +: 2*LANE_W] = res_q[i];
    end

    assign busy = busy_q;
    assign done = done_q;

endmodule

// File: tb/tb_vector_alu.sv
module tb_vector_alu;

    logic          clk;
    logic          rst;
    logic          start;
    logic [1:0]    op;
    logic [511:0]  src_a;
    logic [511:0]  src_b;

    logic          busy4, done4, busy1, done1, busy16, done16;
    logic [1023:0] result4, result1, result16;

    int checks = 0;
    int errors = 0;

    logic [511:0]  img_a, img_b;
    logic [1023:0] res_by_op [4];

    typedef struct {
        logic [1:0]  op;
        int          lane;
        logic [63:0] exp;
    } vec_t;
    vec_t tbl [10];

    vector_alu dut4 (
        .clk(clk), .rst(rst), .start(start), .op(op), .src_a(src_a), .src_b(src_b),
        .busy(busy4), .done(done4), .result(result4)
    );
    vector_alu #(.LANES_PER_CYCLE(1)) dut1 (
        .clk(clk), .rst(rst), .start(start), .op(op), .src_a(src_a), .src_b(src_b),
        .busy(busy1), .done(done1), .result(result1)
    );
    vector_alu #(.LANES_PER_CYCLE(16)) dut16 (
        .clk(clk), .rst(rst), .start(start), .op(op), .src_a(src_a), .src_b(src_b),
        .busy(busy16), .done(done16), .result(result16)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #1000000;
        $display("FAIL watchdog timeout");
        $fatal(1);
    end

    // Behavioural model: plain 64-bit integer arithmetic per lane.
    function automatic logic [1023:0] ref_model(logic [1:0] o, logic [511:0] a, logic [511:0] b);
        logic [1023:0] res;
        res = '0;
        for (int i = 0; i < 16; i++) begin
            int              sa, sb;
            longint unsigned ua, ub;
            longint          r;
            sa = a[i*32 +: 32];
            sb = b[i*32 +: 32];
            ua = {32'h0, a[i*32 +: 32]};
            ub = {32'h0, b[i*32 +: 32]};
            case (o)
                2'b00:   r = longint'(sa) + longint'(sb);
                2'b01:   r = longint'(sa) - longint'(sb);
                2'b10:   r = longint'(sa) * longint'(sb);
                default: r = longint'(ua * ub);
            endcase
            res[i*64 +: 64] = r;
        end
        return res;
    endfunction

    function automatic logic [511:0] rand512();
        logic [511:0] v;
        for (int k = 0; k < 16; k++) v[k*32 +: 32] = $urandom;
        return v;
    endfunction

    task automatic check_int(input string name, input int got, input int exp);
        checks++;
        if (got != exp) begin
            errors++;
            $display("FAIL %s got %0d expected %0d", name, got, exp);
        end
    endtask

    task automatic check64(input string name, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %h expected %h", name, got, exp);
        end
    endtask

    task automatic check_vec(input string name, input logic [1023:0] got,
                             input logic [1023:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            for (int i = 0; i < 16; i++) begin
                if (got[i*64 +: 64] !== exp[i*64 +: 64]) begin
                    $display("FAIL %s lane %0d got %h expected %h", name, i,
                             got[i*64 +: 64], exp[i*64 +: 64]);
                    break;
                end
            end
        end
    endtask

    // Issues one operation to all three builds and checks latency, pulse count and results.
    // Called right after a posedge (+1); returns at the same phase.
    task automatic run_op(input logic [1:0] o, input logic [511:0] a, input logic [511:0] b,
                          input bit scramble, output logic [1023:0] r4);
        int lat4, lat1, lat16, n4, n1, n16, bcnt;
        logic [1023:0] r1, r16, exp;
        lat4 = -1; lat1 = -1; lat16 = -1;
        n4 = 0; n1 = 0; n16 = 0; bcnt = 0;
        r4 = '0; r1 = '0; r16 = '0;
        exp = ref_model(o, a, b);
        op = o; src_a = a; src_b = b; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        if (scramble) begin
            op = 2'($urandom); src_a = rand512(); src_b = rand512();
        end
        for (int e = 0; e < 24; e++) begin
            if (e > 0) begin @(posedge clk); #1; end
            if (busy4) bcnt++;
            if (done4)  begin n4++;  if (lat4 < 0)  lat4 = e;  r4 = result4;   end
            if (done1)  begin n1++;  if (lat1 < 0)  lat1 = e;  r1 = result1;   end
            if (done16) begin n16++; if (lat16 < 0) lat16 = e; r16 = result16; end
        end
        // e counts edges after the start edge; done cycle = e + 1
        check_int("done_cycle_lpc4", lat4 + 1, 5);
        check_int("done_cycle_lpc1", lat1 + 1, 17);
        check_int("done_cycle_lpc16", lat16 + 1, 2);
        check_int("done_count_lpc4", n4, 1);
        check_int("done_count_lpc1", n1, 1);
        check_int("done_count_lpc16", n16, 1);
        check_int("busy_cycles_lpc4", bcnt, 4);
        check_vec("result_lpc4", r4, exp);
        check_vec("result_lpc1", r1, exp);
        check_vec("result_lpc16", r16, exp);
    endtask

    initial begin
        logic [1023:0] r;
        logic [1:0]    seq_ops [3];
        int            pos [3];
        int            k, ndone;

        // Reset images of the register file's A[0]/A[1].
        for (int i = 0; i < 16; i++) begin
            img_a[i*32 +: 32] = 32'h0101_0101 * 32'(i) + 32'h0000_1357;
            img_b[i*32 +: 32] = 32'hF0F0_0000 ^ (32'h0000_0111 * 32'(i));
        end
        img_a[0*32 +: 32]  = 32'h0000_0001; img_b[0*32 +: 32]  = 32'h0000_0001;
        img_a[7*32 +: 32]  = 32'h8000_0000; img_b[7*32 +: 32]  = 32'h8000_0000;
        img_a[10*32 +: 32] = 32'h7FFF_FFFF; img_b[10*32 +: 32] = 32'h8000_0000;
        img_a[12*32 +: 32] = 32'h7FFF_FFFF; img_b[12*32 +: 32] = 32'hFFFF_FFFF;
        img_a[15*32 +: 32] = 32'hFFFF_FFFF; img_b[15*32 +: 32] = 32'hFFFF_FFFF;

        tbl[0] = '{2'b10, 0,  64'h00000000_00000001};
        tbl[1] = '{2'b10, 7,  64'h40000000_00000000};
        tbl[2] = '{2'b10, 10, 64'hC0000000_80000000};
        tbl[3] = '{2'b10, 15, 64'h00000000_00000001};
        tbl[4] = '{2'b11, 15, 64'hFFFFFFFE_00000001};
        tbl[5] = '{2'b11, 10, 64'h3FFFFFFF_80000000};
        tbl[6] = '{2'b00, 12, 64'h00000000_7FFFFFFE};
        tbl[7] = '{2'b00, 15, 64'hFFFFFFFF_FFFFFFFE};
        tbl[8] = '{2'b01, 7,  64'h00000000_00000000};
        tbl[9] = '{2'b01, 0,  64'h00000000_00000000};

        rst = 1'b0; start = 1'b0; op = 2'b00; src_a = '0; src_b = '0;
        #12;
        check_int("reset_busy_lpc4", int'(busy4), 0);
        check_int("reset_done_lpc4", int'(done4), 0);
        check_vec("reset_result_lpc4", result4, '0);
        check_int("reset_busy_lpc1", int'(busy1), 0);
        check_vec("reset_result_lpc1", result1, '0);
        check_vec("reset_result_lpc16", result16, '0);
        rst = 1'b1;
        @(posedge clk); #1;
        repeat (2) begin @(posedge clk); #1; end

        // Each opcode on the reset images, then the spot lanes from the table.
        for (int oi = 0; oi < 4; oi++) begin
            run_op(2'(oi), img_a, img_b, 1'b0, r);
            res_by_op[oi] = r;
        end
        for (int t = 0; t < 10; t++) begin
            check64($sformatf("lane_op%0d_lane%0d", tbl[t].op, tbl[t].lane),
                    res_by_op[tbl[t].op][tbl[t].lane*64 +: 64], tbl[t].exp);
        end

        // Back-to-back: start held high for three operations with different opcodes.
        seq_ops[0] = 2'b10; seq_ops[1] = 2'b00; seq_ops[2] = 2'b01;
        pos[0] = -1; pos[1] = -1; pos[2] = -1;
        k = 0;
        op = seq_ops[0]; src_a = img_a; src_b = img_b; start = 1'b1;
        @(posedge clk); #1;
        for (int e = 0; e < 24; e++) begin
            if (e > 0) begin @(posedge clk); #1; end
            if (e == 14) start = 1'b0;
            if (done4) begin
                if (k < 3) begin
                    pos[k] = e + 1;
                    check_vec($sformatf("b2b_result_%0d", k), result4,
                              ref_model(seq_ops[k], img_a, img_b));
                    if (k < 2) op = seq_ops[k + 1];
                end
                k++;
            end
        end
        check_int("b2b_done_count", k, 3);
        check_int("b2b_done_cycle_0", pos[0], 5);
        check_int("b2b_done_cycle_1", pos[1], 10);
        check_int("b2b_done_cycle_2", pos[2], 15);
        repeat (20) begin @(posedge clk); #1; end

        // A start pulse while busy must not launch a second operation.
        ndone = 0;
        op = 2'b11; src_a = img_a; src_b = img_b; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        for (int e = 0; e < 16; e++) begin
            if (e > 0) begin @(posedge clk); #1; end
            if (e == 1) begin start = 1'b1; op = 2'b00; end
            if (e == 2) start = 1'b0;
            if (done4) begin
                ndone++;
                check_int("ignored_start_done_cycle", e + 1, 5);
                check_vec("ignored_start_result", result4, ref_model(2'b11, img_a, img_b));
            end
        end
        check_int("ignored_start_done_count", ndone, 1);
        repeat (20) begin @(posedge clk); #1; end

        // Random operations; inputs scrambled right after the start edge.
        for (int n = 0; n < 10; n++) begin
            run_op(2'($urandom), rand512(), rand512(), 1'b1, r);
        end

        // Reset in the second RUN cycle aborts everything.
        op = 2'b10; src_a = img_a; src_b = img_b; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        @(posedge clk); #1;
        rst = 1'b0;
        #1;
        check_int("midreset_busy_lpc4", int'(busy4), 0);
        check_int("midreset_done_lpc4", int'(done4), 0);
        check_vec("midreset_result_lpc4", result4, '0);
        check_int("midreset_busy_lpc1", int'(busy1), 0);
        check_vec("midreset_result_lpc16", result16, '0);
        @(posedge clk); #1;
        @(posedge clk); #1;
        rst = 1'b1;
        ndone = 0;
        for (int e = 0; e < 30; e++) begin
            @(posedge clk); #1;
            if (done4 || done1 || done16) ndone++;
        end
        check_int("post_reset_no_done", ndone, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
